// File: rtl/aes256_unloading.sv
// Byte-serial ciphertext collector: pulls 16 bytes from the AES engine and presents a 128-bit block.
// Optional per-byte read timeout is built when AES256_UNLOAD_TIMEOUT_EN is defined.
module aes256_unloading #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pi_enc_done,
  output logic         po_next_val_req,
  input  logic         pi_next_val_ready,
  input  logic [7:0]   pi_data,
  output logic [127:0] po_block,
  output logic         po_block_valid,
  input  logic         pi_block_ready,
  output logic         po_busy,
  output logic         po_overrun,
  output logic         po_timeout_err
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("aes256_unloading: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] idx;
  logic       to_hit;

`ifdef AES256_UNLOAD_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without a byte.
  assign to_hit = (state == WAIT) && !pi_next_val_ready &&
                  (wait_cnt + 16'd1 == 16'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    wait_cnt <= '0;
    else if (state == REQ)                      wait_cnt <= '0;
    else if (state == WAIT && !pi_next_val_ready) wait_cnt <= wait_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              po_timeout_err <= 1'b0;
    else if (state == IDLE && pi_enc_done) po_timeout_err <= 1'b0;
    else if (to_hit)                      po_timeout_err <= 1'b1;
  end
`else
  assign to_hit         = 1'b0;
  assign po_timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (pi_enc_done) state_nx = REQ;
      REQ:  state_nx = WAIT;
      WAIT: begin
        if (pi_next_val_ready) state_nx = (idx == 4'd15) ? DONE : REQ;
        else if (to_hit)       state_nx = IDLE;
      end
      DONE: if (pi_block_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      po_block   <= '0;
      po_overrun <= 1'b0;
    end else begin
      state      <= state_nx;
      po_overrun <= pi_enc_done && (state != IDLE);
      if (state == IDLE && pi_enc_done) begin
        idx <= '0;
      end else if (state == WAIT && pi_next_val_ready) begin
        // Slot idx lives at bit offset 8*(15-idx), i.e. {~idx,3'b000}.
        po_block[{~idx, 3'b000} +: 8] <= pi_data;
        if (idx != 4'd15) idx <= idx + 4'd1;
      end
    end
  end

  assign po_next_val_req = (state == REQ);
  assign po_busy         = (state != IDLE);
  assign po_block_valid  = (state == DONE);

endmodule

// File: doc/aes256_unloading.md
# aes256_unloading

Host-side read collector for the AES-256 loading engine's byte-serial output port. It waits for the engine's encryption-complete indication, then pulls the 16 ciphertext bytes one at a time over the next-value request/ready handshake. It reassembles them MSB-first into a 128-bit block and presents the block downstream on a valid/ready interface. It sits between the engine's `po_enc_done`/`po_next_val_ready`/`po_data` outputs and the system's result consumer.

## Interface
- `TIMEOUT`, default 255: the maximum number of WAIT cycles per byte before the read is aborted. Range 1..65535. Used only when `AES256_UNLOAD_TIMEOUT_EN` is defined.
- `clk` input 1: the single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `pi_enc_done` input 1: the engine's encryption-complete indication.
- `po_next_val_req` output 1: single-cycle request for the next ciphertext byte.
- `pi_next_val_ready` input 1: the engine's byte-valid strobe, qualifying `pi_data`.
- `pi_data` input 8: ciphertext byte.
- `po_block` output 128: the assembled ciphertext. Byte 0 received lands in [127:120].
- `po_block_valid` output 1: `po_block` holds a complete block.
- `pi_block_ready` input 1: downstream accepts the block.
- `po_busy` output 1: high in every state except IDLE.
- `po_overrun` output 1: one-cycle pulse when `pi_enc_done` is high outside IDLE.
- `po_timeout_err` output 1: sticky flag set when a byte timeout occurs.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE.
  - IDLE: if `pi_enc_done` is 1, clear the byte index, clear `po_timeout_err`, and go to REQ.
  - REQ: `po_next_val_req`=1 for exactly this cycle, then go to WAIT. `pi_next_val_ready` is ignored in REQ.
  - WAIT: on `pi_next_val_ready`=1:
    - write `pi_data` into byte slot `idx`, at `po_block[127-8*idx -: 8]`;
    - if `idx`==15, go to DONE; otherwise increment `idx` and go to REQ.
  - DONE: `po_block_valid`=1 and `po_block` is held stable. When `pi_block_ready`=1, go to IDLE.
- Byte index is 4 bits, 0..15, with no wrap-around use; it is cleared on entry from IDLE.
- Slots not yet written in the current read keep their previous contents. Only a completed read asserts valid.
- `pi_enc_done` in REQ, WAIT or DONE:
  - the request is not queued;
  - `po_overrun` pulses for that cycle;
  - the state is unaffected.
- `pi_next_val_ready` in IDLE, REQ or DONE is ignored and captures nothing.
- Reset mid-read: all state returns to the reset values below immediately (asynchronously); partial bytes are discarded.
- Reset values:
  - state IDLE, `idx`=0, `po_block`=0;
  - `po_next_val_req`=0, `po_block_valid`=0, `po_busy`=0, `po_overrun`=0, `po_timeout_err`=0.

## Timing
- All outputs are registered. `po_busy` and `po_block_valid` are decoded from the state register.
- With a zero-wait engine (ready in the first WAIT cycle), each byte costs 2 cycles.
- `pi_enc_done` sampled at edge 0 gives: REQ in cycle 1, WAIT in cycle 2, …, last WAIT in cycle 32, `po_block_valid` from cycle 33.
- Each WAIT cycle without ready adds 1 cycle of latency.
- Block handshake: the transfer happens on the edge where `po_block_valid` and `pi_block_ready` are both 1. `po_block_valid` is 0 in the next cycle.
- Minimum spacing between block reads: 1 IDLE cycle after DONE.
- `po_next_val_req` is never high in two consecutive cycles.

## Configuration
- `AES256_UNLOAD_TIMEOUT_EN` defined:
  - a 16-bit counter clears on REQ and increments each WAIT cycle without ready;
  - when it reaches `TIMEOUT`, the FSM goes to IDLE, sets `po_timeout_err`, and discards partial bytes;
  - `po_timeout_err` is cleared when the next `pi_enc_done` is accepted in IDLE.
- Not defined:
  - no counter is built; WAIT waits indefinitely;
  - `po_timeout_err` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- Zero-wait read:
  - stimulus: `pi_enc_done` pulse; engine returns bytes 0x00..0x0F one cycle after each request; `pi_block_ready`=1.
  - response: `po_block`=128'h000102030405060708090A0B0C0D0E0F, `po_block_valid` at cycle 33, exactly 16 `po_next_val_req` pulses.
- Random wait states (0–5 cycles per byte) and spurious `pi_next_val_ready` in REQ and IDLE:
  - response: the correct block is assembled, no extra captures, and latency is 33 plus the total wait cycles.
- Downstream backpressure, `pi_block_ready` low for 10 cycles:
  - response: `po_block_valid` and `po_block` are held stable, `po_busy`=1, and no new request is issued.
  - also pulse `pi_enc_done` while in DONE: `po_overrun` pulses, and the next read starts only after a fresh `pi_enc_done` in IDLE.
- `rst` asserted mid-read after byte 7:
  - response: all outputs return to reset values asynchronously.
  - a subsequent full read of 0xA0..0xAF yields 128'hA0A1…AF.
- `AES256_UNLOAD_TIMEOUT_EN` with `TIMEOUT`=8, engine silent after byte 3:
  - response: `po_timeout_err`=1 and return to IDLE 8 WAIT cycles after the 4th request; `po_block_valid` never asserts.
  - the next `pi_enc_done` clears `po_timeout_err`.
- Macro undefined, engine stalls 1000 cycles at byte 5, then resumes:
  - response: no error, and the block completes correctly.
